rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (wen/wdest/wdata) among three writeback sources: ALU pipeline, load unit, mul/div unit.
- Holds a pending-write scoreboard so issue logic can stall on RAW/WAW hazards against long-latency ops.
- Sits between the execute/memory units and the register file; its hazard output feeds the decode/issue stall.

Parameters:
XLEN, 32, data width
NREG, 32, architectural register count (rd index width = $clog2(NREG))
STARVE_MAX, 4, consecutive blocked cycles after which a waiting ld/md request overrides ALU priority (1..15)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
alu_valid  in  1  ALU writeback request
alu_rd  in  5  ALU destination
alu_data  in  XLEN  ALU result
alu_ready  out  1  ALU request accepted this cycle
ld_valid  in  1  load writeback request
ld_rd  in  5  load destination
ld_data  in  XLEN  load result
ld_ready  out  1  load request accepted
md_valid  in  1  mul/div writeback request
md_rd  in  5  mul/div destination
md_data  in  XLEN  mul/div result
md_ready  out  1  mul/div request accepted
rsv_valid  in  1  issue of a load or mul/div op; reserve rsv_rd
rsv_rd  in  5  register to reserve
chk_rs1, chk_rs2, chk_rd  in  5 each  registers used by the instruction in issue
hazard  out  1  combinational: instruction in issue must stall
busy  out  NREG  scoreboard bit vector (bit 0 always 0)
rf_wen  out  1  to register file
rf_wdest  out  5  to register file
rf_wdata  out  XLEN  to register file

Behaviour:
- Handshake: transfer when valid && ready on the same clk edge. Requester holds valid/rd/data stable until accepted. Ready is combinational from valids and internal state; at most one ready high per cycle.
- Arbitration:
  - Default: ALU highest priority (alu_ready = alu_valid && !starved).
  - ld vs md: round-robin. rr_ptr selects the preferred unit; after any ld or md grant it points to the other unit. Reset rr_ptr = ld.
  - ld/md granted only if ALU not valid, or starved set.
- Starvation: wait_cnt increments each cycle ld_valid||md_valid is high without an ld/md grant, saturating at STARVE_MAX. starved = (wait_cnt == STARVE_MAX). When starved, alu_ready = 0 and the rr-selected ld/md is granted. wait_cnt clears on any ld/md grant.
- Output register, latency 1:
  - On a grant, rf_wen/rf_wdest/rf_wdata are registered next cycle from the winner's rd/data.
  - rf_wen = 0 if winner rd == 0 (grant still completes).
  - No grant -> rf_wen = 0; rf_wdest/rf_wdata hold their last value.
- Scoreboard:
  - busy[rsv_rd] set at the edge where rsv_valid is high (rsv_rd == 0 ignored).
  - busy[rf_wdest] cleared at the end of a cycle with rf_wen high, but only if that write came from ld/md.
  - Set and clear of the same register on one edge: set wins.
  - Reserve of an already-busy register: stays 1 (no count).
- Hazard:
  - hazard = busy[chk_rs1] || busy[chk_rs2] || busy[chk_rd], each term masked for index 0.
  - A register with rf_wen high and rf_wdest matching in the current cycle is excluded, since the register file forwards write data in that cycle.
- Reset (rst == 0 at clk edge): rf_wen = 0, rf_wdest = 0, rf_wdata = 0, busy = 0, wait_cnt = 0, rr_ptr = ld.
  - All ready outputs are 0 while rst is low.
  - Reset mid-operation drops any in-flight grant: no rf_wen on the following cycle.
- No flush port. Flushed long-latency ops still write back and clear busy.

Test Plan:
- Reset, then alu_valid=1, rd=5, data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle rf_wen=1, wdest=5, wdata=0xDEADBEEF.
- ld_valid and md_valid both held, ALU idle (ld rd=3 data=0x11; md rd=4 data=0x22) -> ld granted first, md next cycle; rf writes in order x3=0x11, x4=0x22; rr alternates across 4 back-to-back pairs.
- alu_valid held every cycle with ld_valid=1 -> ld blocked exactly STARVE_MAX=4 cycles; cycle 5 ld_ready=1, alu_ready=0; wait_cnt returns to 0.
- rsv_valid rd=7, then chk_rs1=7 -> hazard=1 until ld writeback of x7. During the rf_wen cycle with wdest=7, hazard=0; next cycle busy[7]=0.
- rsv_rd=7 on the same edge as the ld writeback clearing x7 -> busy[7] remains 1. rsv_rd=0 -> busy stays 0.
- ALU grant with rd=0 -> alu_ready=1, rf_wen stays 0. Assert rst=0 in the cycle after an ld grant -> rf_wen=0, busy=0, all readies 0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the single register-file write port (ALU / load / mul-div)
// with a pending-write scoreboard that feeds the issue-stage hazard stall.
module rf_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [$clog2(NREG)-1:0]  alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    output logic                     alu_ready,
    input  logic                     ld_valid,
    input  logic [$clog2(NREG)-1:0]  ld_rd,
    input  logic [XLEN-1:0]          ld_data,
    output logic                     ld_ready,
    input  logic                     md_valid,
    input  logic [$clog2(NREG)-1:0]  md_rd,
    input  logic [XLEN-1:0]          md_data,
    output logic                     md_ready,
    input  logic                     rsv_valid,
    input  logic [$clog2(NREG)-1:0]  rsv_rd,
    input  logic [$clog2(NREG)-1:0]  chk_rs1,
    input  logic [$clog2(NREG)-1:0]  chk_rs2,
    input  logic [$clog2(NREG)-1:0]  chk_rd,
    output logic                     hazard,
    output logic [NREG-1:0]          busy,
    output logic                     rf_wen,
    output logic [$clog2(NREG)-1:0]  rf_wdest,
    output logic [XLEN-1:0]          rf_wdata
);
    localparam int RW = $clog2(NREG);
    localparam int CW = 4;
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic {RR_LD = 1'b0, RR_MD = 1'b1} rr_e;

    rr_e             rr_ptr_q,   rr_ptr_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [NREG-1:0] busy_q,     busy_d;
    logic            rf_wen_q,   rf_wen_d;
    logic [RW-1:0]   rf_wdest_q, rf_wdest_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic            wr_lm_q,    wr_lm_d;

    logic            starved;
    logic            lm_allowed;
    logic            alu_gnt;
    logic            ld_gnt;
    logic            md_gnt;
    logic            lm_gnt;
    logic [RW-1:0]   win_rd;
    logic [XLEN-1:0] win_data;

    // A register being written this cycle is forwarded by the register file,
    // so it no longer needs to stall the instruction in issue.
    function automatic logic pend(input logic [NREG-1:0] b, input logic wen,
                                  input logic [RW-1:0] dest, input logic [RW-1:0] r);
        return (r != '0) && b[r] && !(wen && (dest == r));
    endfunction

    always_comb begin
        starved    = (wait_cnt_q == STARVE_LIM);
        alu_gnt    = rst && alu_valid && !starved;
        lm_allowed = rst && (!alu_valid || starved);
        ld_gnt     = lm_allowed && ld_valid && (!md_valid || rr_ptr_q == RR_LD);
        md_gnt     = lm_allowed && md_valid && (!ld_valid || rr_ptr_q == RR_MD);
        lm_gnt     = ld_gnt || md_gnt;

        alu_ready  = alu_gnt;
        ld_ready   = ld_gnt;
        md_ready   = md_gnt;

        hazard = pend(busy_q, rf_wen_q, rf_wdest_q, chk_rs1) ||
                 pend(busy_q, rf_wen_q, rf_wdest_q, chk_rs2) ||
                 pend(busy_q, rf_wen_q, rf_wdest_q, chk_rd);
    end

    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        win_rd   = alu_rd;
        win_data = alu_data;
        if (ld_gnt) begin
            win_rd   = ld_rd;
            win_data = ld_data;
        end else if (md_gnt) begin
            win_rd   = md_rd;
            win_data = md_data;
        end

        rf_wen_d   = 1'b0;
        rf_wdest_d = rf_wdest_q;
        rf_wdata_d = rf_wdata_q;
        wr_lm_d    = 1'b0;
        if (alu_gnt || lm_gnt) begin
            rf_wen_d   = (win_rd != '0);
            rf_wdest_d = win_rd;
            rf_wdata_d = win_data;
            wr_lm_d    = lm_gnt;
        end

        wait_cnt_d = wait_cnt_q;
        if (lm_gnt) begin
            wait_cnt_d = '0;
        end else if ((ld_valid || md_valid) && !starved) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        rr_ptr_d = rr_ptr_q;
        if (ld_gnt) begin
            rr_ptr_d = RR_MD;
        end else if (md_gnt) begin
            rr_ptr_d = RR_LD;
        end

        // Clear first so a same-edge reservation of that register wins.
        busy_d = busy_q;
        if (rf_wen_q && wr_lm_q) begin
            busy_d[rf_wdest_q] = 1'b0;
        end
        if (rsv_valid) begin
            busy_d[rsv_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its _d, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_q   <= RR_LD;
            wait_cnt_q <= '0;
            busy_q     <= '0;
            rf_wen_q   <= 1'b0;
            rf_wdest_q <= '0;
            rf_wdata_q <= '0;
            wr_lm_q    <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wait_cnt_q <= wait_cnt_d;
            busy_q     <= busy_d;
            rf_wen_q   <= rf_wen_d;
            rf_wdest_q <= rf_wdest_d;
            rf_wdata_q <= rf_wdata_d;
            wr_lm_q    <= wr_lm_d;
        end
    end

    assign busy     = busy_q;
    assign rf_wen   = rf_wen_q;
    assign rf_wdest = rf_wdest_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: a reference model predicts grants, busy and
// hazard each cycle and queues expected register-file writes for a separate monitor.
module tb_rf_wb_arbiter;
    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid = 1'b0, ld_valid = 1'b0, md_valid = 1'b0, rsv_valid = 1'b0;
    logic [4:0]  alu_rd = '0, ld_rd = '0, md_rd = '0, rsv_rd = '0;
    logic [4:0]  chk_rs1 = '0, chk_rs2 = '0, chk_rd = '0;
    logic [31:0] alu_data = '0, ld_data = '0, md_data = '0;
    logic        alu_ready, ld_ready, md_ready, hazard, rf_wen;
    logic [31:0] busy;
    logic [4:0]  rf_wdest;
    logic [31:0] rf_wdata;

    int total = 0;
    int bad   = 0;

    rf_wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
        .rsv_valid(rsv_valid), .rsv_rd(rsv_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
        .hazard(hazard), .busy(busy),
        .rf_wen(rf_wen), .rf_wdest(rf_wdest), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    int         blocked = 0;       // cycles an ld/md request has waited
    int         pref    = 2;       // preferred long-latency unit: 2 = ld, 3 = md
    bit [31:0]  m_busy  = '0;
    bit         cur_wen = 1'b0;    // write the register file sees this cycle
    int         cur_rd  = 0;
    bit         cur_lm  = 1'b0;
    int         granted = 0;       // 0 none, 1 alu, 2 ld, 3 md (decision of last cycle)

    function automatic bit pend_m(input logic [4:0] r);
        return (r != 0) && m_busy[r] && !(cur_wen && cur_rd == int'(r));
    endfunction

    always @(negedge clk) begin
        int  win;
        bit  starved;
        wr_t e;
        check("busy", busy, m_busy);
        check("hazard", hazard, pend_m(chk_rs1) || pend_m(chk_rs2) || pend_m(chk_rd));

        win     = 0;
        starved = (blocked == STARVE_MAX);
        if (rst) begin
            if (alu_valid && !starved) win = 1;
            else if (ld_valid && md_valid) win = pref;
            else if (ld_valid) win = 2;
            else if (md_valid) win = 3;
        end
        check("alu_ready", alu_ready, win == 1);
        check("ld_ready", ld_ready, win == 2);
        check("md_ready", md_ready, win == 3);
        granted = win;

        if (!rst) begin
            blocked = 0;
            pref    = 2;
            m_busy  = '0;
            cur_wen = 1'b0;
            cur_lm  = 1'b0;
        end else begin
            if (cur_wen && cur_lm) m_busy[cur_rd] = 1'b0;
            if (rsv_valid && rsv_rd != 0) m_busy[rsv_rd] = 1'b1;
            if (win >= 2) begin
                blocked = 0;
                pref    = (win == 2) ? 3 : 2;
            end else if ((ld_valid || md_valid) && blocked < STARVE_MAX) begin
                blocked++;
            end
            cur_wen = 1'b0;
            cur_lm  = (win >= 2);
            if (win != 0) begin
                e.rd   = (win == 1) ? alu_rd   : (win == 2) ? ld_rd   : md_rd;
                e.data = (win == 1) ? alu_data : (win == 2) ? ld_data : md_data;
                if (e.rd != 0) begin
                    cur_wen = 1'b1;
                    cur_rd  = int'(e.rd);
                    exp_q.push_back(e);
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        wr_t e;
        #2;
        check("rf_wen", rf_wen, exp_q.size() > 0);
        if (rf_wen && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rf_wdest", rf_wdest, e.rd);
            check("rf_wdata", rf_wdata, e.data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        alu_valid = 1'b0; ld_valid = 1'b0; md_valid = 1'b0; rsv_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  n;
        bit  seen;
        do_reset();

        // ALU single write
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1 check("t1_alu_ready", alu_ready, 1'b1);
        tick();
        alu_valid = 1'b0;
        check("t1_wen", rf_wen, 1'b1);
        check("t1_wdest", rf_wdest, 5'd5);
        check("t1_wdata", rf_wdata, 32'hDEADBEEF);
        tick();

        // ld and md contend with ALU idle: strict alternation starting with ld
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h11;
        md_valid = 1'b1; md_rd = 5'd4; md_data = 32'h22;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t2_order", rf_wdest, (i % 2 == 0) ? 5'd3 : 5'd4);
        end
        ld_valid = 1'b0; md_valid = 1'b0;
        tick();

        // starvation: ALU keeps the port busy, ld wins on its fifth cycle
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1234;
        ld_valid  = 1'b1; ld_rd  = 5'd9; ld_data  = 32'h99;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = ld_ready;
            check("t3_alu_blocked", alu_ready, !seen);
            tick();
        end
        check("t3_starve_wait", n, 5);
        ld_valid = 1'b0;
        check("t3_ld_write", rf_wdest, 5'd9);
        tick();
        tick();
        alu_valid = 1'b0;
        tick();

        // reservation, hazard, forwarding window, clear
        do_reset();
        rsv_valid = 1'b1; rsv_rd = 5'd7;
        tick();
        rsv_valid = 1'b0; chk_rs1 = 5'd7;
        #1 check("t4_haz", hazard, 1'b1);
        tick();
        tick();
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h77;
        tick();
        ld_valid = 1'b0;
        check("t4_wen", rf_wen, 1'b1);
        check("t4_haz_fwd", hazard, 1'b0);
        tick();
        check("t4_busy7_clr", busy[7], 1'b0);
        check("t4_haz_clr", hazard, 1'b0);

        // reserve on the same edge the ld writeback clears the register
        rsv_valid = 1'b1; rsv_rd = 5'd7;
        tick();
        rsv_valid = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h78;
        tick();
        ld_valid = 1'b0;
        rsv_valid = 1'b1; rsv_rd = 5'd7;
        tick();
        rsv_valid = 1'b0;
        check("t5_busy7_set_wins", busy[7], 1'b1);
        rsv_valid = 1'b1; rsv_rd = 5'd0;
        tick();
        rsv_valid = 1'b0;
        check("t5_busy0", busy[0], 1'b0);

        // ALU write to x0 completes without rf_wen; reset right after an ld grant
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hAAAA;
        #1 check("t6_alu_ready_x0", alu_ready, 1'b1);
        tick();
        alu_valid = 1'b0;
        check("t6_no_wen_x0", rf_wen, 1'b0);
        ld_valid = 1'b1; ld_rd = 5'd6; ld_data = 32'h66;
        tick();
        ld_valid = 1'b0;
        rst = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd2; md_valid = 1'b1; md_rd = 5'd2;
        #1 check("t6_ready_in_rst", {alu_ready, ld_ready, md_ready}, 3'b000);
        tick();
        check("t6_wen_after_rst", rf_wen, 1'b0);
        check("t6_busy_after_rst", busy, 32'h0);
        alu_valid = 1'b0; md_valid = 1'b0;
        rst = 1'b1;
        tick();

        // randomized traffic under the handshake rules
        for (int c = 0; c < 3000; c++) begin
            if (alu_valid && granted == 1) alu_valid = 1'b0;
            if (ld_valid  && granted == 2) ld_valid  = 1'b0;
            if (md_valid  && granted == 3) md_valid  = 1'b0;
            if (!alu_valid && $urandom_range(0, 99) < 45) begin
                alu_valid = 1'b1; alu_rd = 5'($urandom_range(0, 7)); alu_data = $urandom;
            end
            if (!ld_valid && $urandom_range(0, 99) < 30) begin
                ld_valid = 1'b1; ld_rd = 5'($urandom_range(0, 7)); ld_data = $urandom;
            end
            if (!md_valid && $urandom_range(0, 99) < 30) begin
                md_valid = 1'b1; md_rd = 5'($urandom_range(0, 7)); md_data = $urandom;
            end
            rsv_valid = ($urandom_range(0, 3) == 0);
            rsv_rd    = 5'($urandom_range(0, 7));
            chk_rs1   = 5'($urandom_range(0, 7));
            chk_rs2   = 5'($urandom_range(0, 7));
            chk_rd    = 5'($urandom_range(0, 7));
            rst       = ($urandom_range(0, 199) != 0);
            tick();
        end

        rst = 1'b1;
        alu_valid = 1'b0; ld_valid = 1'b0; md_valid = 1'b0; rsv_valid = 1'b0;
        tick();
        tick();
        tick();
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
